// File: rtl/haar_scan_scheduler.sv
// haar_scan_scheduler: walks every window of the six Haar filter scales over one core tile and collects face results.
module haar_scan_scheduler #(
  parameter int CW = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CW-1:0]    unit_size,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    core_side,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [CW-1:0]    win_x,
  output logic [CW-1:0]    win_y,
  output logic [CW-1:0]    win_w,
  output logic [CW-1:0]    win_h,
  output logic [CW-1:0]    win_eye,
  output logic [2:0]       win_stage,
  input  logic             res_valid,
  input  logic             res_face,
  output logic             face_valid,
  output logic [CNT_W-1:0] win_count,
  output logic [15:0]      det_count
);
  localparam int PW = CW + 4;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [PW-1:0] K5 = PW'(5);
  localparam logic [PW-1:0] K6 = PW'(6);
  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, ADV, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] u_q, u_d, core_side_q, core_side_d, x_q, x_d, y_q, y_d;
  logic [CW-1:0] w_q, w_d, h_q, h_d, eye_q, eye_d;
  logic [2:0] stage_q, stage_d;
  logic busy_q, busy_d, done_q, done_d, win_valid_q, win_valid_d, face_valid_q, face_valid_d;
  logic [CNT_W-1:0] win_count_q, win_count_d;
  logic [15:0] det_count_q, det_count_d;
  logic [PW-1:0] num, den, prod, wf, fh;
  logic skip, x_last, y_last;
  always_comb begin
    // each scale derives from the previous one; stage 1 derives from U
    num = PW'(stage_q == 3'd1 ? 2 : stage_q <= 3'd3 ? 3 : stage_q == 3'd4 ? 4 : stage_q == 3'd5 ? 5 : 6);
    den = PW'(stage_q == 3'd1 ? 3 : stage_q <= 3'd3 ? 2 : stage_q == 3'd4 ? 3 : stage_q == 3'd5 ? 4 : 5);
    prod = PW'(stage_q == 3'd1 ? u_q : w_q) * num;
    wf = prod / den - PW'(stage_q == 3'd6);
    fh = wf / K6;
    skip = fh == '0 || wf >= PW'(core_side_q) || (fh << 2) >= PW'(core_side_q);
    x_last = x_q + w_q + ONE == core_side_q;
    y_last = y_q + (h_q << 2) + ONE == core_side_q;
    state_d = state_q;
    u_d = u_q;
    core_side_d = core_side_q;
    x_d = x_q;
    y_d = y_q;
    w_d = w_q;
    h_d = h_q;
    eye_d = eye_q;
    stage_d = stage_q;
    face_valid_d = 1'b0;
    win_count_d = win_count_q;
    det_count_d = det_count_q;
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        u_d = unit_size;
        core_side_d = unit_size + unit_size + unit_size;
        x_d = '0;
        y_d = '0;
        stage_d = 3'd1;
        win_count_d = '0;
        det_count_d = '0;
        state_d = CALC;
      end
      CALC: begin
        w_d = CW'(wf);
        h_d = CW'(fh);
        eye_d = CW'(wf / K5);
        x_d = '0;
        y_d = '0;
        stage_d = skip && stage_q != 3'd6 ? stage_q + 3'd1 : stage_q;
        state_d = !skip ? ISSUE : stage_q == 3'd6 ? DONE : CALC;
      end
      ISSUE: if (win_ready) begin
        win_count_d = win_count_q + CNT_W'(1);
        state_d = WAIT;
      end
      WAIT: if (res_valid) begin
        face_valid_d = res_face;
        det_count_d = det_count_q + 16'(res_face && det_count_q != 16'hFFFF);
        state_d = ADV;
      end
      ADV: begin
        x_d = x_last ? '0 : x_q + ONE;
        y_d = !x_last ? y_q : y_last ? '0 : y_q + ONE;
        stage_d = x_last && y_last && stage_q != 3'd6 ? stage_q + 3'd1 : stage_q;
        state_d = !(x_last && y_last) ? ISSUE : stage_q == 3'd6 ? DONE : CALC;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
    win_valid_d = state_d == ISSUE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      u_q <= '0;
      core_side_q <= '0;
      x_q <= '0;
      y_q <= '0;
      w_q <= '0;
      h_q <= '0;
      eye_q <= '0;
      stage_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      win_valid_q <= 1'b0;
      face_valid_q <= 1'b0;
      win_count_q <= '0;
      det_count_q <= '0;
    end else begin
      state_q <= state_d;
      u_q <= u_d;
      core_side_q <= core_side_d;
      x_q <= x_d;
      y_q <= y_d;
      w_q <= w_d;
      h_q <= h_d;
      eye_q <= eye_d;
      stage_q <= stage_d;
      busy_q <= busy_d;
      done_q <= done_d;
      win_valid_q <= win_valid_d;
      face_valid_q <= face_valid_d;
      win_count_q <= win_count_d;
      det_count_q <= det_count_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign core_side = core_side_q;
  assign win_valid = win_valid_q;
  assign win_x = x_q;
  assign win_y = y_q;
  assign win_w = w_q;
  assign win_h = h_q;
  assign win_eye = eye_q;
  assign win_stage = stage_q;
  assign face_valid = face_valid_q;
  assign win_count = win_count_q;
  assign det_count = det_count_q;
endmodule
